spectro_code_decoder: RTL and testbench
=======================================

Name: spectro_code_decoder

Overview:
- Receive end of the 3-bit channel-code stream: the code is the highest active band channel (1..7), or 0 for silence.
- Decodes each code back to a one-hot channel vector.
- Accumulates per-channel hit counts over a fixed frame of samples, then unloads the frame histogram channel by channel over a valid/ready interface.
- Sits between the code source (pins or on-chip encoder) and the readout/serialiser logic.

Parameters:
- FRAME_LEN, 256, number of code_valid samples per frame; legal range 2..65535.
- CNT_W, 8, width of each per-channel counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- code_in  input  3  channel code; 0 = silence, k = channel k (1..7).
- code_valid  input  1  code_in sample strobe, one sample per cycle when high.
- onehot_out  output  7  registered decode of the last valid code.
- frame_done  output  1  one-cycle pulse when a frame closes.
- out_valid  output  1  histogram entry available.
- out_ready  input  1  consumer accepts the entry.
- out_ch  output  3  channel index of the current entry, 1..7.
- out_cnt  output  CNT_W  hit count for out_ch in the unloaded frame.
- overrun  output  1  sticky: a frame closed while the previous one was still unloading.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low on rst_n; rst_n is sampled async on assertion. Release is synchronous to clk.
- Reset values:
  - Outputs: onehot_out=0, frame_done=0, out_valid=0, out_ch=1, out_cnt=0, overrun=0.
  - Internal state: live counters 0, shadow counters 0, sample counter 0, state IDLE.
- Reset mid-frame or mid-unload: all partial data is discarded. No entry is emitted after rst_n falls.
- Decode:
  - On a cycle with code_valid=1, next cycle onehot_out = (code_in==0) ? 0 : 1<<(code_in-1). Latency is 1 cycle.
  - onehot_out holds its value while code_valid=0.
- Accumulation runs continuously, independent of the unload state:
  - Each valid nonzero code increments live counter[code_in].
  - Counters saturate at 2^CNT_W-1; no wrap.
  - Code 0 increments no channel counter, but it counts as a sample.
- Sample counter:
  - Increments on every code_valid.
  - The sample with counter == FRAME_LEN-1 closes the frame and is included in that frame.
- Frame close, in the cycle after the closing sample:
  - frame_done pulses high for 1 cycle.
  - Live counters are cleared; the sample counter goes to 0.
  - If state is IDLE: the live values, including the closing sample, are copied into the shadow bank and state goes to DUMP.
- State IDLE: out_valid=0.
- State DUMP:
  - out_valid=1, with out_ch running from 1 to 7 in order and out_cnt = shadow[out_ch].
  - out_ch and out_cnt stay stable until out_valid&&out_ready.
  - On each transfer out_ch advances. A transfer at out_ch=7 returns the state to IDLE, with out_ch reset to 1.
  - Each frame unloads exactly 7 entries, minimum 7 cycles.
- Overrun: a frame closes while the state is DUMP (excluding the case below).
  - The new frame is dropped: live counters are cleared and the shadow bank is untouched.
  - overrun is set and stays set until reset.
  - The unload in progress continues unaffected.
- Simultaneous event: frame close in the same cycle as the final (ch7) transfer.
  - Not an overrun.
  - The new snapshot is taken and DUMP restarts at out_ch=1 with no idle gap.
- A frame close on the same cycle as a code_valid of the next frame is impossible: one sample per cycle.

Decomposition:
- Shared package spectro_pkg:
  - N_CH=7, CODE_W=3.
  - State enum {IDLE, DUMP}.
  - A function code_to_onehot(code) returning the 7-bit vector. The encoder side reuses this package for its inverse.
- Natural sub-module: spectro_hist_bank.
  - Holds the 7 live and 7 shadow saturating counters.
  - Inputs: inc-enable + index, clear, snapshot.
  - Read port indexed by out_ch.
- Top level holds the sample counter, the FSM, the handshake and the overrun logic.

Test Plan (bench uses FRAME_LEN=8, CNT_W=4 unless noted):
- Decode sweep:
  - Stimulus: codes 0..7, one per cycle, code_valid=1.
  - Required: onehot_out one cycle later = 00,01,02,04,08,10,20,40 hex.
  - Then code_valid=0 with code_in=3: onehot_out stays 40.
- Single frame:
  - Stimulus: codes 1,1,3,7,0,3,3,7, then out_ready=1.
  - Required: frame_done pulses once; 7 entries (ch1..7) = 2,0,3,0,0,0,2.
  - out_valid drops after ch7.
- Backpressure:
  - Stimulus: same frame, out_ready toggled 1-0-0-1 per cycle.
  - Required: out_ch/out_cnt stable while out_ready=0; no entry skipped or duplicated.
- Saturation and overrun:
  - Stimulus: CNT_W=2, eight codes of 5, out_ready=0 held; then a second frame of 8 codes.
  - Required: ch5 count reads 3 when unloaded.
  - On the second frame close: overrun=1, frame_done pulses, and the unloaded data is still frame 1.
- Back-to-back boundary:
  - Stimulus: continuous valid codes; out_ready timed so the ch7 transfer coincides with the next frame close.
  - Required: overrun stays 0; the next cycle shows out_valid=1, out_ch=1, with new-frame data.
- Async reset mid-unload:
  - Stimulus: drop rst_n between clock edges while out_ch=4.
  - Required: out_valid=0, overrun=0, onehot_out=0 immediately.
  - After release, the first frame counts from zero.

Source files
------------

// File: rtl/spectro_pkg.sv
// spectro_pkg: shared constants, FSM state and code/one-hot mapping for the spectro channel-code path.
package spectro_pkg;
  localparam int N_CH = 7;
  localparam int CODE_W = 3;
  typedef enum logic {IDLE, DUMP} state_t;
  function automatic logic [N_CH-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return (code == '0) ? '0 : N_CH'(1) << (code - 1'b1);
  endfunction
endpackage

// File: rtl/spectro_hist_bank.sv
// spectro_hist_bank: live and shadow banks of saturating per-channel hit counters.
module spectro_hist_bank
  import spectro_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic [CODE_W-1:0] i_idx,
  input  logic              i_clr,
  input  logic              i_snap,
  input  logic [CODE_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0]  o_rd_cnt
);
  logic [CNT_W-1:0] r_live   [N_CH];
  logic [CNT_W-1:0] r_shadow [N_CH];
  logic [CNT_W-1:0] w_next   [N_CH];
  // Code 0 matches no channel, so silence counts nothing here.
  always_comb
    for (int i = 0; i < N_CH; i++)
      w_next[i] = (i_inc && i_idx == CODE_W'(i + 1) && r_live[i] != '1) ? r_live[i] + 1'b1 : r_live[i];
  // The snapshot takes the next-live value so the closing sample lands in the frame it closes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_live[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_live[i] <= i_clr ? '0 : w_next[i];
        if (i_snap) r_shadow[i] <= w_next[i];
      end
    end
  assign o_rd_cnt = r_shadow[i_rd_idx - 1'b1];
endmodule

// File: rtl/spectro_code_decoder.sv
// spectro_code_decoder: decodes channel codes to one-hot, histograms them per frame
// and unloads each frame's histogram over valid/ready.
module spectro_code_decoder
  import spectro_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic [N_CH-1:0]   onehot_out,
  output logic              frame_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_ch,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              overrun
);
  localparam int SMP_W = $clog2(FRAME_LEN);
  state_t            r_state, w_state_nxt;
  logic [SMP_W-1:0]  r_smp;
  logic [CODE_W-1:0] r_ch;
  logic [N_CH-1:0]   r_onehot;
  logic              r_done, r_ovr;
  logic              w_close, w_xfer, w_last, w_snap;
  assign w_close = code_valid && r_smp == SMP_W'(FRAME_LEN - 1);
  assign w_xfer  = out_valid && out_ready;
  assign w_last  = w_xfer && r_ch == CODE_W'(N_CH);
  // A close coinciding with the final transfer is a clean hand-off, not an overrun.
  assign w_snap  = w_close && (r_state == IDLE || w_last);
  spectro_hist_bank #(.CNT_W(CNT_W)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (code_valid),
    .i_idx    (code_in),
    .i_clr    (w_close),
    .i_snap   (w_snap),
    .i_rd_idx (r_ch),
    .o_rd_cnt (out_cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb w_state_nxt = w_snap ? DUMP : w_last ? IDLE : r_state;
  always_comb out_valid = r_state == DUMP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_smp    <= '0;
      r_ch     <= CODE_W'(1);
      r_onehot <= '0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_smp    <= code_valid ? (w_close ? '0 : r_smp + 1'b1) : r_smp;
      r_ch     <= w_xfer ? (w_last ? CODE_W'(1) : r_ch + 1'b1) : r_ch;
      r_onehot <= code_valid ? code_to_onehot(code_in) : r_onehot;
      r_done   <= w_close;
      r_ovr    <= r_ovr || (w_close && !w_snap);
    end
  assign onehot_out = r_onehot;
  assign frame_done = r_done;
  assign out_ch     = r_ch;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_spectro_code_decoder.sv
// tb_spectro_code_decoder: directed table-driven bench; a CNT_W=4 and a CNT_W=2 instance share stimulus.
module tb_spectro_code_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] a_onehot, b_onehot;
  logic       a_done, b_done, a_valid, b_valid, a_ovr, b_ovr;
  logic [2:0] a_ch, b_ch;
  logic [3:0] a_cnt;
  logic [1:0] b_cnt;
  int n_pass = 0;
  int n_tot = 0;
  int ea[7];
  typedef struct {
    logic [2:0] code;
    logic       valid;
    logic [6:0] exp;
  } dec_t;
  dec_t dv[9];

  always #5 clk = ~clk;

  spectro_code_decoder #(.FRAME_LEN(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .onehot_out(a_onehot), .frame_done(a_done), .out_valid(a_valid), .out_ready(out_ready),
    .out_ch(a_ch), .out_cnt(a_cnt), .overrun(a_ovr)
  );
  spectro_code_decoder #(.FRAME_LEN(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .onehot_out(b_onehot), .frame_done(b_done), .out_valid(b_valid), .out_ready(out_ready),
    .out_ch(b_ch), .out_cnt(b_cnt), .overrun(b_ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    code_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] c);
    code_in = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  // Unloads all seven entries with out_ready held high; the CNT_W=2 copy must read the saturated value.
  task automatic unload(input string tag);
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      chk({tag, "_valid"}, a_valid, 1);
      chk({tag, "_ch"}, a_ch, k);
      chk({tag, "_cnt4"}, a_cnt, ea[k-1]);
      chk({tag, "_cnt2"}, b_cnt, (ea[k-1] > 3) ? 3 : ea[k-1]);
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_idle"}, a_valid, 0);
  endtask

  initial begin
    logic [2:0] sf[8];
    int         idx;
    sf = '{3'd1, 3'd1, 3'd3, 3'd7, 3'd0, 3'd3, 3'd3, 3'd7};
    dv = '{'{3'd0, 1'b1, 7'h00}, '{3'd1, 1'b1, 7'h01}, '{3'd2, 1'b1, 7'h02},
           '{3'd3, 1'b1, 7'h04}, '{3'd4, 1'b1, 7'h08}, '{3'd5, 1'b1, 7'h10},
           '{3'd6, 1'b1, 7'h20}, '{3'd7, 1'b1, 7'h40}, '{3'd3, 1'b0, 7'h40}};

    do_reset();
    chk("rst_onehot", a_onehot, 0);
    chk("rst_done", a_done, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_ch", a_ch, 1);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ovr", a_ovr, 0);

    for (int i = 0; i < 9; i++) begin
      code_in = dv[i].code;
      code_valid = dv[i].valid;
      tick();
      chk("decode", a_onehot, dv[i].exp);
    end
    code_valid = 1'b0;

    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("sf_nodone", a_done, 0);
      send(sf[i]);
    end
    chk("sf_done", a_done, 1);
    ea = '{2, 0, 3, 0, 0, 0, 2};
    unload("sf");
    chk("sf_done_once", a_done, 0);

    do_reset();
    for (int i = 0; i < 8; i++) send(sf[i]);
    idx = 1;
    for (int c = 0; c < 40 && idx <= 7; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      chk("bp_valid", a_valid, 1);
      chk("bp_ch", a_ch, idx);
      chk("bp_cnt", a_cnt, ea[idx-1]);
      tick();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    chk("bp_count", idx, 8);
    chk("bp_idle", a_valid, 0);

    do_reset();
    for (int i = 0; i < 8; i++) send(3'd5);
    chk("sat_done1", a_done, 1);
    chk("sat_ovr0", a_ovr, 0);
    for (int i = 0; i < 8; i++) send(3'd2);
    chk("ovr_done2", a_done, 1);
    chk("ovr_set4", a_ovr, 1);
    chk("ovr_set2", b_ovr, 1);
    chk("ovr_ch", a_ch, 1);
    ea = '{0, 0, 0, 0, 8, 0, 0};
    unload("sat");
    chk("ovr_sticky", a_ovr, 1);

    do_reset();
    for (int i = 0; i < 8; i++) send((i == 7) ? 3'd1 : 3'(i + 1));
    chk("b2b_doneA", a_done, 1);
    ea = '{2, 1, 1, 1, 1, 1, 1};
    for (int j = 0; j < 8; j++) begin
      code_in = 3'd6;
      code_valid = 1'b1;
      out_ready = (j >= 1);
      chk("b2b_validA", a_valid, 1);
      chk("b2b_chA", a_ch, (j == 0) ? 1 : j);
      chk("b2b_cntA", a_cnt, ea[(j == 0) ? 0 : j-1]);
      tick();
    end
    code_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_doneB", a_done, 1);
    chk("b2b_ovr", a_ovr, 0);
    chk("b2b_valid", a_valid, 1);
    chk("b2b_ch", a_ch, 1);
    ea = '{0, 0, 0, 0, 0, 8, 0};
    unload("b2b");

    do_reset();
    for (int i = 0; i < 8; i++) send(3'd1);
    for (int i = 0; i < 8; i++) send(3'd2);
    chk("ar_ovr_pre", a_ovr, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(3'd4);
    out_ready = 1'b0;
    chk("ar_ch_pre", a_ch, 4);
    chk("ar_oh_pre", a_onehot, 7'h08);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", a_valid, 0);
    chk("ar_ovr", a_ovr, 0);
    chk("ar_onehot", a_onehot, 0);
    chk("ar_ch", a_ch, 1);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send(3'd4);
    chk("ar_nodone", a_done, 0);
    chk("ar_noval", a_valid, 0);
    send(3'd4);
    chk("ar_done", a_done, 1);
    ea = '{0, 0, 0, 8, 0, 0, 0};
    unload("ar");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
